// File: rtl/signal_head_seq.sv
// Lamp sequencer: one-hot approach grant -> red/yellow/green lamp drives with safe clearance.
// Optional FLASH_ON_FAULT_EN: flash all reds while a fault holds the intersection all-red.
`timescale 1ns/1ps
module signal_head_seq #(
    parameter int YELLOW_CYCLES  = 3,
    parameter int ALL_RED_CYCLES = 2,
    parameter int FLASH_HALF     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] grant,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [3:0] red,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2
    } state_t;

    localparam int CNT_MAX = (YELLOW_CYCLES > ALL_RED_CYCLES) ? YELLOW_CYCLES : ALL_RED_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] YEL_LOAD = CW'(YELLOW_CYCLES);
    localparam logic [CW-1:0] AR_LOAD  = CW'(ALL_RED_CYCLES);

    if (YELLOW_CYCLES < 1 || ALL_RED_CYCLES < 1 || FLASH_HALF < 1) begin : g_param_check
        $error("signal_head_seq: cycle parameters must be >= 1");
    end

    state_t          state_q, state_d;
    logic [3:0]      active_q, active_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            grant_valid;
    logic            fault_d;
    logic            lamp_on_d;
    logic [3:0]      green_d, yellow_d, red_d;
    logic            busy_d;

    assign grant_valid = (grant != 4'b0000) && ((grant & (grant - 4'd1)) == 4'b0000);
    assign fault_d     = ~grant_valid;

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        cnt_d    = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        case (state_q)
            ST_ALL_RED: begin
                // counter at 1 is the sample cycle; 0 means held expired after an invalid sample
                if (cnt_q <= CW'(1)) begin
                    cnt_d = '0;
                    if (grant_valid) begin
                        active_d = grant;
                        state_d  = ST_GREEN;
                    end
                end
            end
            ST_GREEN: begin
                if (grant != active_q) begin
                    state_d = ST_YELLOW;
                    cnt_d   = YEL_LOAD;
                end
            end
            ST_YELLOW: begin
                if (cnt_q <= CW'(1)) begin
                    state_d  = ST_ALL_RED;
                    active_d = '0;
                    cnt_d    = AR_LOAD;
                end
            end
            default: begin
                state_d  = ST_ALL_RED;
                active_d = '0;
                cnt_d    = AR_LOAD;
            end
        endcase
    end

`ifdef FLASH_ON_FAULT_EN
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic          flash_on_q, flash_on_d;
    logic          flash_act_q, flash_act_d;

    // phase and count describe what is currently displayed, so a new flash always starts lit
    always_comb begin
        flash_act_d = fault_d && (state_d == ST_ALL_RED);
        flash_cnt_d = '0;
        flash_on_d  = 1'b1;
        if (flash_act_d && flash_act_q) begin
            if (flash_cnt_q == FLASH_LAST) begin
                flash_on_d = ~flash_on_q;
            end else begin
                flash_cnt_d = flash_cnt_q + FW'(1);
                flash_on_d  = flash_on_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flash_cnt_q <= '0;
            flash_on_q  <= 1'b1;
            flash_act_q <= 1'b0;
        end else begin
            flash_cnt_q <= flash_cnt_d;
            flash_on_q  <= flash_on_d;
            flash_act_q <= flash_act_d;
        end
    end

    assign lamp_on_d = flash_on_d;
`else
    assign lamp_on_d = 1'b1;
`endif

    always_comb begin
        green_d  = (state_d == ST_GREEN)  ? active_d : 4'b0000;
        yellow_d = (state_d == ST_YELLOW) ? active_d : 4'b0000;
        red_d    = ~(green_d | yellow_d) & {4{lamp_on_d}};
        busy_d   = (state_d != ST_GREEN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ALL_RED;
            active_q <= '0;
            cnt_q    <= AR_LOAD;
            green    <= '0;
            yellow   <= '0;
            red      <= '1;
            busy     <= 1'b1;
            fault    <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            green    <= green_d;
            yellow   <= yellow_d;
            red      <= red_d;
            busy     <= busy_d;
            fault    <= fault_d;
        end
    end

endmodule

// File: doc/signal_head_seq.md
# signal_head_seq

Lamp sequencer that sits downstream of the traffic light controller and turns its one-hot approach grant (`traffic[4:1]`) into per-approach red/yellow/green lamp drives. Each change of grant becomes a safe green → yellow → all-red → green sequence. Invalid grants are detected and force the intersection to all-red.

## Interface
- `YELLOW_CYCLES`, 3, yellow clearance length in clock cycles (≥1)
- `ALL_RED_CYCLES`, 2, all-red interval length in clock cycles (≥1)
- `FLASH_HALF`, 4, half-period in cycles of the fault red flash (≥1; used only with `FLASH_ON_FAULT_EN`)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset, synchronous, active-high
- `grant`  in  4  one-hot approach grant from the controller; bit i = approach i
- `green`  out  4  green lamp per approach
- `yellow`  out  4  yellow lamp per approach
- `red`  out  4  red lamp per approach
- `busy`  out  1  high while in YELLOW or ALL_RED
- `fault`  out  1  high while the last sampled `grant` was invalid (zero or multi-hot)

## Operation
- Internal registers: state, `active[4:1]` (approach currently green, one-hot or zero), phase counter, flash counter and phase.
- Valid grant = exactly one bit set.
- States and transitions:
  - ALL_RED: every `red`=1. Counter runs `ALL_RED_CYCLES` cycles. At the last cycle, sample `grant`:
    - valid: `active` ← `grant`, go to GREEN.
    - invalid: stay ALL_RED with the counter held expired, and re-sample every cycle.
  - GREEN: `green[active]`=1, all other `red`=1.
    - `grant` == `active`: stay.
    - `grant` differs, either another valid approach or invalid: go to YELLOW and load the counter.
  - YELLOW: `yellow[active]`=1, others red. Runs for `YELLOW_CYCLES` cycles. Then go to ALL_RED, clear `active`, and load the counter.
- `grant` is ignored during YELLOW and the non-final ALL_RED cycles. The value present at the ALL_RED sample point wins, including a return to the previous approach.
- Per approach, exactly one of `green`/`yellow`/`red` is high (except during flashing with the macro). At most one approach is non-red at any time.
- `fault` updates on every edge from the current `grant` validity, in all states.
- The counter is sized for max(`YELLOW_CYCLES`, `ALL_RED_CYCLES`). It decrements and saturates at 0 and never wraps.

## Timing
- All outputs are registered. A change on `grant` before edge k is reflected in outputs right after edge k, so latency is 1 cycle.
- Yellow is high for exactly `YELLOW_CYCLES` cycles. All-red lasts exactly `ALL_RED_CYCLES` cycles when the grant is valid at the sample point.
- Grant-change to new green with defaults: 1 + 3 + 2 = new green visible 6 cycles after the grant change was sampled.
- Reset (any state, any cycle):
  - state = ALL_RED, counter loaded with `ALL_RED_CYCLES`, `active`=0.
  - `red`=4'b1111, `green`=0, `yellow`=0, `busy`=1, `fault`=0, flash phase = lamps on.
  - The first green appears `ALL_RED_CYCLES` cycles after reset deasserts.
- Simultaneous events:
  - Grant changes again during YELLOW: the sequence is not restarted or extended.
  - Grant invalid at the exact sample edge: ALL_RED is held, and `fault`=1 from the next cycle.

## Configuration
- `FLASH_ON_FAULT_EN` defined: while `fault`=1 and state is ALL_RED, all four `red` bits toggle every `FLASH_HALF` cycles, starting from on. The flash counter resets when `fault` clears, and `red` returns steady on the next cycle.
- Not defined: `red` stays steady 4'b1111 during a fault. The flash counter and `FLASH_HALF` logic are absent.

## Test plan
- Reset, then `grant`=4'b0001 → `red`=1111 for 2 cycles, then `green`=0001 and `red`=1110; `busy` falls with green.
- In GREEN on approach 1, `grant`→0100 → `yellow`=0001 for 3 cycles, then `red`=1111 for 2 cycles, then `green`=0100.
- During YELLOW, `grant` goes 0100→1000→0001 and is 0001 at the sample point → green returns on 0001 with full yellow and all-red intervals observed.
- `grant`=0011 while green on 0010 → yellow 3 cycles, all-red held indefinitely, `fault`=1; then `grant`=1000 → `fault`=0 and `green`=1000 on the next edge.
- Assert `rst` mid-YELLOW → next cycle `red`=1111, `yellow`=0, `fault`=0, `busy`=1.
- With `FLASH_ON_FAULT_EN`, `grant`=0000 held for 20 cycles → `red` alternates 1111/0000 every 4 cycles. Without the macro → `red` steady 1111.
